deconv3x3: RTL and testbench
============================

Name: deconv3x3

Overview:
- Transposed 3x3 convolution, stride 2, padding 1, output_padding 1: maps an H×W feature map to 2H×2W.
- It is the decoder-side counterpart of conv3x3 and is used in the synthesis/upsampling path of the codec.
- Sequential gather-form engine with one signed MAC per cycle and a start/busy/done handshake.
- Tensors use the same flat-vector packing as conv3x3.

Parameters:
- DATA_WIDTH, 32, signed two's-complement element width.
- BATCH_SIZE, 1, batch count.
- IN_CHANNELS, 1, input channels.
- OUT_CHANNELS, 1, output channels.
- IN_HEIGHT, 4, input rows.
- IN_WIDTH, 4, input columns.
- OUT_HEIGHT, 2*IN_HEIGHT, derived; do not override.
- OUT_WIDTH, 2*IN_WIDTH, derived; do not override.
- ACC_WIDTH, 2*DATA_WIDTH+8, accumulator width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin; honoured only in IDLE.
- input_tensor_flat  in  BATCH_SIZE*IN_CHANNELS*IN_HEIGHT*IN_WIDTH*DATA_WIDTH  element (b,ic,iy,ix) at flat index ((b*IC+ic)*IH+iy)*IW+ix.
- weights_flat  in  IN_CHANNELS*OUT_CHANNELS*9*DATA_WIDTH  element (ic,oc,ky,kx) at ((ic*OC+oc)*3+ky)*3+kx (PyTorch ConvTranspose2d order).
- bias_flat  in  OUT_CHANNELS*DATA_WIDTH  per-output-channel bias.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last element is written.
- output_tensor_flat  out  BATCH_SIZE*OUT_CHANNELS*OUT_HEIGHT*OUT_WIDTH*DATA_WIDTH  element (b,oc,oy,ox) at ((b*OC+oc)*OH+oy)*OW+ox.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; busy=0; done=0.
  - output_tensor_flat=0; all counters and accumulator cleared.
  - Applies immediately, including mid-computation; no partial results survive.
- States and transitions:
  - IDLE: start=1 → INIT.
  - INIT: acc←sign-extended bias[oc]; ic=ky=kx=0 → MAC.
  - MAC: one tap per cycle; kx innermost, then ky, then ic. After the IC*9th tap → WRITE.
  - WRITE: element (b,oc,oy,ox) ← sat(acc). Advance ox, then oy, then oc, then b. If more elements remain → INIT, else → DONE.
  - DONE: done=1 for one cycle → IDLE.
- Tap rule:
  - ty=oy+1-ky, tx=ox+1-kx.
  - The tap is valid iff ty and tx are even and non-negative, iy=ty/2<IH and ix=tx/2<IW.
  - Valid: acc += in[b][ic][iy][ix]*w[ic][oc][ky][kx], full-width signed product.
  - Invalid: acc unchanged; the cycle is still consumed (data-independent timing).
- Latency:
  - Exactly B*OC*OH*OW*(IC*9+2) cycles from the start-sampling edge to DONE.
  - done asserts the following cycle.
- Saturation: acc > 2^(DW-1)-1 → 2^(DW-1)-1; acc < -2^(DW-1) → -2^(DW-1); otherwise the low DW bits.
- Output update rules:
  - Each element updates only in its own WRITE cycle. Elements not yet rewritten keep their prior values; there is no bulk clear on start.
  - After done, output holds until the next start or reset.
- Input stability: the flat inputs are read combinationally and must stay stable while busy. Changing them mid-run is unspecified.
- start handling:
  - start while busy, or in INIT/MAC/WRITE/DONE, is ignored; no queueing.
  - start in the same cycle done pulses is ignored.
- Odd sizes: IN_HEIGHT=1 or IN_WIDTH=1 is legal; the boundary taps fall out of range per the rule above.

Decomposition:
- Package deconv_pkg holds:
  - state enum (IDLE, INIT, MAC, WRITE, DONE);
  - ACC_WIDTH helper;
  - flat-index functions for input, weight and output;
  - signed saturate function.
- Sub-module deconv_mac:
  - clear/load-bias, enable-accumulate, saturated DATA_WIDTH result;
  - a registered multiply-accumulate holding acc.
- The top level holds the FSM, the loop counters, the tap-validity and index logic, and the output register bank.

Test Plan:
- IH=IW=2, IC=OC=1, input [1,2,3,4], all weights 1, bias 0, start → output rows [1,3,2,2],[4,10,6,6],[3,7,4,4],[3,7,4,4]; done exactly 16*11=176 cycles after the start edge; busy high throughout.
- Same input, only w[1][1]=2, bias 5 → out[2iy][2ix]=2*in+5 (7,9,11,13), all other elements 5.
- DATA_WIDTH=8, input 127, all weights 127, bias 0 → every element 127 (positive saturation). Input -128 → every element -128.
- IC=2, OC=2, input ch0 all 1, ch1 all 2, weights w[ic][oc]=oc+1, bias [0,100] → each oc1 element equals 100+2×(oc0 element); done after B*2*OH*OW*20 cycles.
- Pulse start again 10 cycles into a run → ignored, with cycle count and results identical to an undisturbed run.
- Assert rst low mid-MAC → busy=0, done=0 and output all 0 immediately. A fresh start then produces the correct full result.

Source files
------------

// File: rtl/deconv_pkg.sv
// Shared types and helpers for the stride-2 transposed 3x3 convolution engine:
// FSM states, accumulator sizing, flat-vector index maps and signed saturation.
package deconv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        MAC,
        WRITE,
        DONE
    } state_t;

    // Wide enough for any accumulator this engine is built with.
    localparam int SAT_W = 128;

    function automatic int acc_width(input int dw);
        return 2 * dw + 8;
    endfunction

    function automatic int in_index(input int b, input int ic, input int iy, input int ix,
                                    input int n_ic, input int n_ih, input int n_iw);
        return ((b * n_ic + ic) * n_ih + iy) * n_iw + ix;
    endfunction

    function automatic int w_index(input int ic, input int oc, input int ky, input int kx,
                                   input int n_oc);
        return ((ic * n_oc + oc) * 3 + ky) * 3 + kx;
    endfunction

    function automatic int out_index(input int b, input int oc, input int oy, input int ox,
                                     input int n_oc, input int n_oh, input int n_ow);
        return ((b * n_oc + oc) * n_oh + oy) * n_ow + ox;
    endfunction

    function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] a,
                                                         input int dw);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (SAT_W'(1) <<< (dw - 1)) - SAT_W'(1);
        lo = -(SAT_W'(1) <<< (dw - 1));
        if (a > hi)
            return hi;
        else if (a < lo)
            return lo;
        else
            return a;
    endfunction

endpackage

// File: rtl/deconv_mac.sv
// Registered signed multiply-accumulate: loads bias on clear, adds one full-width
// product per enabled cycle, and presents the accumulator saturated to DATA_WIDTH.
module deconv_mac
    import deconv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 72
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_clear,
    input  logic                         i_en,
    input  logic signed [DATA_WIDTH-1:0] i_bias,
    input  logic signed [DATA_WIDTH-1:0] i_a,
    input  logic signed [DATA_WIDTH-1:0] i_b,
    output logic signed [DATA_WIDTH-1:0] o_result
);

    logic signed [ACC_WIDTH-1:0]    r_acc;
    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic signed [SAT_W-1:0]        w_acc_ext;

    assign w_prod    = i_a * i_b;
    assign w_acc_ext = SAT_W'(r_acc);
    assign o_result  = DATA_WIDTH'(saturate(w_acc_ext, DATA_WIDTH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_acc <= '0;
        else if (i_clear)
            r_acc <= ACC_WIDTH'(i_bias);
        else if (i_en)
            r_acc <= r_acc + ACC_WIDTH'(w_prod);
    end

endmodule

// File: rtl/deconv3x3.sv
// Transposed 3x3 convolution (stride 2, pad 1, output_padding 1) in gather form:
// one output element at a time, one kernel tap per cycle, fixed data-independent timing.
module deconv3x3
    import deconv_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int BATCH_SIZE   = 1,
    parameter int IN_CHANNELS  = 1,
    parameter int OUT_CHANNELS = 1,
    parameter int IN_HEIGHT    = 4,
    parameter int IN_WIDTH     = 4,
    parameter int OUT_HEIGHT   = 2 * IN_HEIGHT,
    parameter int OUT_WIDTH    = 2 * IN_WIDTH,
    parameter int ACC_WIDTH    = acc_width(DATA_WIDTH)
) (
    input  logic                                                              clk,
    input  logic                                                              rst,
    input  logic                                                              start,
    input  logic [BATCH_SIZE*IN_CHANNELS*IN_HEIGHT*IN_WIDTH*DATA_WIDTH-1:0]   input_tensor_flat,
    input  logic [IN_CHANNELS*OUT_CHANNELS*9*DATA_WIDTH-1:0]                  weights_flat,
    input  logic [OUT_CHANNELS*DATA_WIDTH-1:0]                                bias_flat,
    output logic                                                              busy,
    output logic                                                              done,
    output logic [BATCH_SIZE*OUT_CHANNELS*OUT_HEIGHT*OUT_WIDTH*DATA_WIDTH-1:0] output_tensor_flat
);

    localparam int OUT_BITS = BATCH_SIZE * OUT_CHANNELS * OUT_HEIGHT * OUT_WIDTH * DATA_WIDTH;

    state_t r_state;
    state_t w_next;

    int r_b, r_oc, r_oy, r_ox;
    int r_ic, r_ky, r_kx;

    int   w_ty, w_tx;
    int   w_in_idx, w_w_idx, w_out_idx;
    logic w_tap_ok, w_last_tap, w_last_elem;
    logic w_clear, w_en;

    logic signed [DATA_WIDTH-1:0] w_x, w_wt, w_bias, w_result;
    logic [OUT_BITS-1:0]          r_out;

    // Gather form: output (oy,ox) pulls input (ty/2,tx/2) only when both offsets land on the stride grid.
    always_comb begin
        w_ty        = r_oy + 1 - r_ky;
        w_tx        = r_ox + 1 - r_kx;
        w_tap_ok    = (w_ty >= 0) && (w_tx >= 0) && !w_ty[0] && !w_tx[0]
                      && ((w_ty >>> 1) < IN_HEIGHT) && ((w_tx >>> 1) < IN_WIDTH);
        w_in_idx    = w_tap_ok ? in_index(r_b, r_ic, w_ty >>> 1, w_tx >>> 1,
                                          IN_CHANNELS, IN_HEIGHT, IN_WIDTH) : 0;
        w_w_idx     = w_index(r_ic, r_oc, r_ky, r_kx, OUT_CHANNELS);
        w_out_idx   = out_index(r_b, r_oc, r_oy, r_ox, OUT_CHANNELS, OUT_HEIGHT, OUT_WIDTH);
        w_last_tap  = (r_ic == IN_CHANNELS - 1) && (r_ky == 2) && (r_kx == 2);
        w_last_elem = (r_ox == OUT_WIDTH - 1) && (r_oy == OUT_HEIGHT - 1)
                      && (r_oc == OUT_CHANNELS - 1) && (r_b == BATCH_SIZE - 1);
    end

    assign w_x     = input_tensor_flat[w_in_idx*DATA_WIDTH +: DATA_WIDTH];
    assign w_wt    = weights_flat[w_w_idx*DATA_WIDTH +: DATA_WIDTH];
    assign w_bias  = bias_flat[r_oc*DATA_WIDTH +: DATA_WIDTH];
    assign w_clear = (r_state == INIT);
    assign w_en    = (r_state == MAC) && w_tap_ok;

    deconv_mac #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .i_en    (w_en),
        .i_bias  (w_bias),
        .i_a     (w_x),
        .i_b     (w_wt),
        .o_result(w_result)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start)
                    w_next = INIT;
            end
            INIT: begin
                busy   = 1'b1;
                w_next = MAC;
            end
            MAC: begin
                busy = 1'b1;
                if (w_last_tap)
                    w_next = WRITE;
            end
            WRITE: begin
                busy   = 1'b1;
                w_next = w_last_elem ? DONE : INIT;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Counters stop on their final value so the index functions never see out-of-range operands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_b  <= 0;
            r_oc <= 0;
            r_oy <= 0;
            r_ox <= 0;
            r_ic <= 0;
            r_ky <= 0;
            r_kx <= 0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_b  <= 0;
                        r_oc <= 0;
                        r_oy <= 0;
                        r_ox <= 0;
                    end
                end
                INIT: begin
                    r_ic <= 0;
                    r_ky <= 0;
                    r_kx <= 0;
                end
                MAC: begin
                    if (!w_last_tap) begin
                        if (r_kx < 2) begin
                            r_kx <= r_kx + 1;
                        end else begin
                            r_kx <= 0;
                            if (r_ky < 2) begin
                                r_ky <= r_ky + 1;
                            end else begin
                                r_ky <= 0;
                                r_ic <= r_ic + 1;
                            end
                        end
                    end
                end
                WRITE: begin
                    if (!w_last_elem) begin
                        if (r_ox < OUT_WIDTH - 1) begin
                            r_ox <= r_ox + 1;
                        end else begin
                            r_ox <= 0;
                            if (r_oy < OUT_HEIGHT - 1) begin
                                r_oy <= r_oy + 1;
                            end else begin
                                r_oy <= 0;
                                if (r_oc < OUT_CHANNELS - 1) begin
                                    r_oc <= r_oc + 1;
                                end else begin
                                    r_oc <= 0;
                                    r_b  <= r_b + 1;
                                end
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_out <= '0;
        else if (r_state == WRITE)
            r_out[w_out_idx*DATA_WIDTH +: DATA_WIDTH] <= w_result;
    end

    assign output_tensor_flat = r_out;

endmodule

// File: tb/tb_deconv3x3.sv
// Directed bench for deconv3x3: 2x2 single-channel vectors, 8-bit saturation,
// two-channel mixing, ignored start pulses and asynchronous reset mid-run.
module tb_deconv3x3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // A: DW=32, 2x2, IC=OC=1
    logic         a_start, a_busy, a_done;
    logic [127:0] a_in;
    logic [287:0] a_w;
    logic [31:0]  a_bias;
    logic [511:0] a_out;

    // S: DW=8, 2x2, IC=OC=1
    logic         s_start, s_busy, s_done;
    logic [31:0]  s_in;
    logic [71:0]  s_w;
    logic [7:0]   s_bias;
    logic [127:0] s_out;

    // M: DW=32, 2x2, IC=OC=2
    logic          m_start, m_busy, m_done;
    logic [255:0]  m_in;
    logic [1151:0] m_w;
    logic [63:0]   m_bias;
    logic [1023:0] m_out;

    deconv3x3 #(.DATA_WIDTH(32), .IN_HEIGHT(2), .IN_WIDTH(2)) u_a (
        .clk(clk), .rst(rst), .start(a_start),
        .input_tensor_flat(a_in), .weights_flat(a_w), .bias_flat(a_bias),
        .busy(a_busy), .done(a_done), .output_tensor_flat(a_out)
    );

    deconv3x3 #(.DATA_WIDTH(8), .IN_HEIGHT(2), .IN_WIDTH(2)) u_s (
        .clk(clk), .rst(rst), .start(s_start),
        .input_tensor_flat(s_in), .weights_flat(s_w), .bias_flat(s_bias),
        .busy(s_busy), .done(s_done), .output_tensor_flat(s_out)
    );

    deconv3x3 #(.DATA_WIDTH(32), .IN_CHANNELS(2), .OUT_CHANNELS(2),
                .IN_HEIGHT(2), .IN_WIDTH(2)) u_m (
        .clk(clk), .rst(rst), .start(m_start),
        .input_tensor_flat(m_in), .weights_flat(m_w), .bias_flat(m_bias),
        .busy(m_busy), .done(m_done), .output_tensor_flat(m_out)
    );

    typedef struct packed {
        logic [3:0][31:0]  in;
        logic [8:0][31:0]  w;
        logic [31:0]       bias;
        logic [15:0][31:0] expv;
    } vec_t;

    vec_t vecs[4];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic set_start(input int which, input logic v);
        case (which)
            0: a_start = v;
            1: s_start = v;
            default: m_start = v;
        endcase
    endtask

    function automatic logic get_done(input int which);
        case (which)
            0: return a_done;
            1: return s_done;
            default: return m_done;
        endcase
    endfunction

    function automatic logic get_busy(input int which);
        case (which)
            0: return a_busy;
            1: return s_busy;
            default: return m_busy;
        endcase
    endfunction

    // Starts a run and counts edges after the start-sampling edge until done is seen.
    task automatic run(input int which, input int restart_at, input logic poke_done,
                       input string tag, output int cycles);
        logic busy_ok;
        busy_ok = 1'b1;
        @(negedge clk);
        set_start(which, 1'b1);
        @(posedge clk);
        #1 set_start(which, 1'b0);
        cycles = 0;
        while (cycles < 3000) begin
            @(posedge clk);
            cycles++;
            #1;
            set_start(which, cycles == restart_at);
            if (get_done(which))
                break;
            if (!get_busy(which))
                busy_ok = 1'b0;
        end
        chk({tag, "_busy_during_run"}, longint'(busy_ok), 1);
        if (poke_done)
            set_start(which, 1'b1);
        @(posedge clk);
        #1 set_start(which, 1'b0);
        chk({tag, "_done_one_cycle"}, longint'(get_done(which)), 0);
        if (poke_done) begin
            chk({tag, "_start_at_done_ignored"}, longint'(get_busy(which)), 0);
            @(posedge clk);
            #1 chk({tag, "_still_idle"}, longint'(get_busy(which)), 0);
        end
    endtask

    task automatic check_a(input int v, input string tag);
        for (int k = 0; k < 16; k++)
            chk($sformatf("%s_out%0d", tag, k), longint'($signed(a_out[k*32 +: 32])),
                longint'($signed(vecs[v].expv[k])));
    endtask

    initial begin
        int cyc;
        int t0[16];
        int rows[4];

        rst     = 1'b0;
        a_start = 1'b0; s_start = 1'b0; m_start = 1'b0;
        a_in = '0; a_w = '0; a_bias = '0;
        s_in = '0; s_w = '0; s_bias = '0;
        m_in = '0; m_w = '0; m_bias = '0;

        #23;
        chk("reset_busy", longint'(a_busy), 0);
        chk("reset_done", longint'(a_done), 0);
        chk("reset_out_nonzero", longint'(a_out != '0), 0);
        @(negedge clk);
        rst = 1'b1;

        t0 = '{1, 3, 2, 2, 4, 10, 6, 6, 3, 7, 4, 4, 3, 7, 4, 4};
        for (int i = 0; i < 4; i++) begin
            vecs[i] = '0;
            for (int k = 0; k < 4; k++)
                vecs[i].in[k] = (i == 3) ? -(k + 1) : (k + 1);
        end
        for (int k = 0; k < 9; k++) vecs[0].w[k] = 1;
        for (int k = 0; k < 16; k++) vecs[0].expv[k] = t0[k];
        vecs[1].w[4] = 2;
        vecs[1].bias = 5;
        for (int k = 0; k < 16; k++) vecs[1].expv[k] = 5;
        vecs[1].expv[0] = 7; vecs[1].expv[2] = 9; vecs[1].expv[8] = 11; vecs[1].expv[10] = 13;
        vecs[2].w[0] = 3;
        vecs[2].bias = -1;
        for (int k = 0; k < 16; k++) vecs[2].expv[k] = -1;
        vecs[2].expv[5] = 11;
        vecs[3].w[8] = 1;
        vecs[3].expv[5] = -1; vecs[3].expv[7] = -2; vecs[3].expv[13] = -3; vecs[3].expv[15] = -4;

        for (int i = 0; i < 4; i++) begin
            a_in   = vecs[i].in;
            a_w    = vecs[i].w;
            a_bias = vecs[i].bias;
            run(0, 0, 1'b0, $sformatf("v%0d", i), cyc);
            chk($sformatf("v%0d_latency", i), cyc, 176);
            check_a(i, $sformatf("v%0d", i));
        end

        // Extra start mid-run and start on the done cycle must both be ignored.
        a_in = vecs[0].in; a_w = vecs[0].w; a_bias = vecs[0].bias;
        run(0, 10, 1'b1, "restart", cyc);
        chk("restart_latency", cyc, 176);
        check_a(0, "restart");

        // 8-bit saturation, both polarities.
        s_in = {4{8'h7f}};
        s_w  = {9{8'h7f}};
        run(1, 0, 1'b0, "satpos", cyc);
        chk("satpos_latency", cyc, 176);
        for (int k = 0; k < 16; k++)
            chk($sformatf("satpos_out%0d", k), longint'($signed(s_out[k*8 +: 8])), 127);
        s_in = {4{8'h80}};
        run(1, 0, 1'b0, "satneg", cyc);
        for (int k = 0; k < 16; k++)
            chk($sformatf("satneg_out%0d", k), longint'($signed(s_out[k*8 +: 8])), -128);

        // Two channels: each output is (tap count) * sum over ic of in*w, plus bias.
        for (int k = 0; k < 8; k++) m_in[k*32 +: 32] = (k < 4) ? 32'd1 : 32'd2;
        for (int e = 0; e < 36; e++) m_w[e*32 +: 32] = 32'((e / 9) % 2 + 1);
        m_bias = {32'd100, 32'd0};
        run(2, 0, 1'b0, "mc", cyc);
        chk("mc_latency", cyc, 640);
        rows = '{1, 2, 1, 1};
        for (int oy = 0; oy < 4; oy++)
            for (int ox = 0; ox < 4; ox++) begin
                chk($sformatf("mc_oc0_%0d_%0d", oy, ox),
                    longint'($signed(m_out[(oy*4+ox)*32 +: 32])), 3 * rows[oy] * rows[ox]);
                chk($sformatf("mc_oc1_%0d_%0d", oy, ox),
                    longint'($signed(m_out[(16+oy*4+ox)*32 +: 32])), 100 + 6 * rows[oy] * rows[ox]);
            end

        // Asynchronous reset between edges while in MAC, then a clean rerun.
        @(negedge clk);
        a_start = 1'b1;
        @(posedge clk);
        #1 a_start = 1'b0;
        repeat (30) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("midreset_busy", longint'(a_busy), 0);
        chk("midreset_done", longint'(a_done), 0);
        chk("midreset_out_nonzero", longint'(a_out != '0), 0);
        @(negedge clk);
        rst = 1'b1;
        run(0, 0, 1'b0, "after_reset", cyc);
        chk("after_reset_latency", cyc, 176);
        check_a(0, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
